mems_scan_sequencer: RTL and testbench



---
 rtl/mems_scan_pkg.sv | 25 ++
 rtl/mems_scan_sequencer_if.sv | 24 ++
 rtl/mems_scan_cnt.sv | 44 ++++
 rtl/mems_scan_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mems_scan_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mems_scan_pkg.sv
// mems_scan_pkg: shared state encoding, default geometry and init addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mems_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INIT_RST  = 2'd1,
    ST_INIT_VREF = 2'd2,
    ST_SCAN      = 2'd3
  } state_t;

  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_INIT_RST_ADDR   = 0;
  localparam int DEF_INIT_VREF_ADDR  = 1;
  localparam int DEF_SCAN_BASE       = 8;
  localparam int DEF_PTS_PER_LINE    = 480;
  localparam int DEF_LINES_PER_FRAME = 18;

  // Index width that stays at least one bit for degenerate counts of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mems_scan_sequencer_if.sv
// mems_scan_sequencer_if: SPI-master handshake plus line/frame marker handshake.
// Latency: n/a (wiring only).
// Backpressure: mems_SPI_busy stalls issue; *_FIFO_done acknowledges the markers.
interface mems_scan_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              mems_SPI_start;
  logic [ADDR_W-1:0] addr;
  logic              mems_SPI_busy;
  logic              new_line;
  logic              new_frame;
  logic              new_line_FIFO_done;
  logic              new_frame_FIFO_done;

  modport master (
    output mems_SPI_start, addr, new_line, new_frame,
    input  mems_SPI_busy, new_line_FIFO_done, new_frame_FIFO_done
  );

  modport slave (
    input  mems_SPI_start, addr, new_line, new_frame,
    output mems_SPI_busy, new_line_FIFO_done, new_frame_FIFO_done
  );
endinterface

// File: rtl/mems_scan_cnt.sv
// mems_scan_cnt: point-within-line and line-within-frame counter with end flags.
// Latency: counts update one edge after adv/clr; flags are decoded from the current count.
// Backpressure: none; advances only when the sequencer issues a scan point.
module mems_scan_cnt
  import mems_scan_pkg::*;
#(
  parameter int PTS_PER_LINE    = DEF_PTS_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
)(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr,
  input  logic                                 adv,
  output logic [idx_w(LINES_PER_FRAME)-1:0]    line,
  output logic                                 last_pt,
  output logic                                 last_line
);
  localparam int PW = idx_w(PTS_PER_LINE);
  localparam int LW = idx_w(LINES_PER_FRAME);

  logic [PW-1:0] point;

  assign last_pt   = (point == PW'(PTS_PER_LINE - 1));
  assign last_line = (line == LW'(LINES_PER_FRAME - 1));

  // Point counter wraps per line; line counter wraps per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      point <= '0;
      line  <= '0;
    end else if (clr) begin
      point <= '0;
      line  <= '0;
    end else if (adv) begin
      if (last_pt) begin
        point <= '0;
        line  <= last_line ? '0 : line + 1'b1;
      end else begin
        point <= point + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mems_scan_sequencer.sv
// mems_scan_sequencer: DAC init (soft reset, Vref) then raster of scan-ROM addresses with line/frame markers.
// Latency: all outputs registered; start and addr change on the same edge; at most one start every 2 cycles.
// Backpressure: issue waits on mems_SPI_busy (and pause in SCAN); markers held until FIFO ack. MEMS_SCAN_OVERRUN_EN adds overrun.
module mems_scan_sequencer
  import mems_scan_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int INIT_RST_ADDR   = DEF_INIT_RST_ADDR,
  parameter int INIT_VREF_ADDR  = DEF_INIT_VREF_ADDR,
  parameter int SCAN_BASE       = DEF_SCAN_BASE,
  parameter int PTS_PER_LINE    = DEF_PTS_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
)(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mems_soft_reset,
  input  logic                              single_frame,
  input  logic                              pause,
  mems_scan_sequencer_if.master             bus,
  output logic                              scan_active,
  output logic [idx_w(LINES_PER_FRAME)-1:0] line_idx
`ifdef MEMS_SCAN_OVERRUN_EN
  ,
  output logic                              overrun
`endif
);
  localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(INIT_RST_ADDR);
  localparam logic [ADDR_W-1:0] VREF_A = ADDR_W'(INIT_VREF_ADDR);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(SCAN_BASE);
  localparam longint SPAN = longint'(SCAN_BASE) + longint'(PTS_PER_LINE) * longint'(LINES_PER_FRAME);

  // The raster must fit in the address space and the geometry must be usable.
  generate
    if (SPAN > (64'sd1 <<< ADDR_W) || PTS_PER_LINE < 2 || LINES_PER_FRAME < 1) begin : g_bad_geom
      $error("mems_scan_sequencer: illegal scan geometry for ADDR_W");
    end
  endgenerate

  state_t            state_q, state_d;
  logic              abort_q, abort_d;
  logic              start_d;
  logic [ADDR_W-1:0] addr_d;
  logic              cnt_clr, cnt_adv;
  logic              cnt_last_pt, cnt_last_line;
  logic              set_line, set_frame, clr_markers;
  logic              ready;

  // A start is never issued back-to-back: one idle cycle lets busy rise.
  assign ready = !bus.mems_SPI_busy && !bus.mems_SPI_start;

  mems_scan_cnt #(
    .PTS_PER_LINE    (PTS_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .adv       (cnt_adv),
    .line      (line_idx),
    .last_pt   (cnt_last_pt),
    .last_line (cnt_last_line)
  );

  // Next-state, next-address and marker-set decisions.
  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    start_d     = 1'b0;
    addr_d      = bus.addr;
    cnt_clr     = 1'b0;
    cnt_adv     = 1'b0;
    set_line    = 1'b0;
    set_frame   = 1'b0;
    clr_markers = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d  = RST_A;
        abort_d = 1'b0;
        if (mems_soft_reset) begin
          start_d = 1'b1;
          state_d = ST_INIT_RST;
        end
      end
      default: begin
        if (mems_soft_reset || abort_q) begin
          // Abort is remembered until the in-flight transaction drains.
          if (ready) begin
            start_d     = 1'b1;
            addr_d      = RST_A;
            state_d     = ST_INIT_RST;
            clr_markers = 1'b1;
            cnt_clr     = 1'b1;
            abort_d     = 1'b0;
          end else begin
            abort_d = 1'b1;
          end
        end else if (ready) begin
          case (state_q)
            ST_INIT_RST: begin
              start_d = 1'b1;
              addr_d  = VREF_A;
              state_d = ST_INIT_VREF;
            end
            ST_INIT_VREF: begin
              start_d = 1'b1;
              addr_d  = BASE_A;
              cnt_clr = 1'b1;
              state_d = ST_SCAN;
            end
            ST_SCAN: begin
              if (!pause) begin
                cnt_adv = 1'b1;
                if (cnt_last_pt && cnt_last_line) begin
                  set_frame = 1'b1;
                  if (single_frame) begin
                    addr_d  = RST_A;
                    state_d = ST_IDLE;
                  end else begin
                    addr_d  = BASE_A;
                    start_d = 1'b1;
                  end
                end else begin
                  set_line = cnt_last_pt;
                  addr_d   = bus.addr + 1'b1;
                  start_d  = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State and registered SPI-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      abort_q            <= 1'b0;
      bus.mems_SPI_start <= 1'b0;
      bus.addr           <= RST_A;
      scan_active        <= 1'b0;
    end else begin
      state_q            <= state_d;
      abort_q            <= abort_d;
      bus.mems_SPI_start <= start_d;
      bus.addr           <= addr_d;
      scan_active        <= (state_d == ST_SCAN);
    end
  end

  // Sticky markers: a new set beats a coincident acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.new_line  <= 1'b0;
      bus.new_frame <= 1'b0;
    end else if (clr_markers) begin
      bus.new_line  <= 1'b0;
      bus.new_frame <= 1'b0;
    end else begin
      if (set_line)                     bus.new_line  <= 1'b1;
      else if (bus.new_line_FIFO_done)  bus.new_line  <= 1'b0;
      if (set_frame)                    bus.new_frame <= 1'b1;
      else if (bus.new_frame_FIFO_done) bus.new_frame <= 1'b0;
    end
  end

`ifdef MEMS_SCAN_OVERRUN_EN
  // Flag a marker re-set while the previous one is still unacknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (mems_soft_reset) begin
      overrun <= 1'b0;
    end else if ((set_line && bus.new_line && !bus.new_line_FIFO_done) ||
                 (set_frame && bus.new_frame && !bus.new_frame_FIFO_done)) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mems_scan_sequencer.sv
`timescale 1ns/1ps
// tb_mems_scan_sequencer: directed scenarios against default geometry (480 x 18, base 8).
// Latency: starts expected every 2 cycles with busy low.
// Backpressure: busy/pause/ack scenarios driven by the tasks below.
module tb_mems_scan_sequencer;
  import mems_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mems_soft_reset = 1'b0;
  logic       single_frame = 1'b0;
  logic       pause = 1'b0;
  logic       scan_active;
  logic [4:0] line_idx;
`ifdef MEMS_SCAN_OVERRUN_EN
  logic       overrun;
`endif

  mems_scan_sequencer_if #(.ADDR_W(16)) bus ();

  mems_scan_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mems_soft_reset (mems_soft_reset),
    .single_frame    (single_frame),
    .pause           (pause),
    .bus             (bus.master),
    .scan_active     (scan_active),
    .line_idx        (line_idx)
`ifdef MEMS_SCAN_OVERRUN_EN
    ,
    .overrun         (overrun)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1500000", $time);
    $fatal(1, "watchdog expired");
  end

  // Wait up to budget negedges for a start pulse; returns its address and cycle.
  task automatic next_start(input int budget, output logic [15:0] a, output int c, output bit ok);
    ok = 1'b0;
    a  = '0;
    c  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.mems_SPI_start === 1'b1) begin
        ok = 1'b1;
        a  = bus.addr;
        c  = cyc;
        break;
      end
    end
  endtask

  // Scan forward until the start carrying target; counts non-2-cycle spacings.
  task automatic run_to(input logic [15:0] target, input int max_pts, input bit auto_ack,
                        output bit ok, output int bad_gaps);
    logic [15:0] a;
    int          c, prev;
    bit          got;
    ok       = 1'b0;
    bad_gaps = 0;
    prev     = -1;
    for (int k = 0; k < max_pts; k++) begin
      next_start(16, a, c, got);
      if (!got) break;
      if (prev >= 0 && (c - prev) != 2) bad_gaps++;
      prev = c;
      if (auto_ack) bus.new_line_FIFO_done = bus.new_line;
      if (a == target) begin
        ok = 1'b1;
        break;
      end
    end
    bus.new_line_FIFO_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.mems_SPI_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b required 0", bus.mems_SPI_start); end
    tests++; if (bus.addr !== 16'd0) begin fails++; $display("FAIL reset_addr: got %0d required 0", bus.addr); end
    tests++; if (bus.new_line !== 1'b0 || bus.new_frame !== 1'b0) begin fails++; $display("FAIL reset_markers: got %b%b required 00", bus.new_line, bus.new_frame); end
    tests++; if (scan_active !== 1'b0 || line_idx !== 5'd0) begin fails++; $display("FAIL reset_scan: got %b/%0d required 0/0", scan_active, line_idx); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.mems_SPI_start !== 1'b0) begin fails++; $display("FAIL idle_no_start: got %b required 0", bus.mems_SPI_start); end
  endtask

  task automatic test_init_sequence();
    logic [15:0] a;
    int          c, prev;
    bit          ok;
    logic [15:0] exp_a [3];
    exp_a = '{16'd1, 16'd8, 16'd9};
    mems_soft_reset = 1'b1;
    @(negedge clk);
    mems_soft_reset = 1'b0;
    tests++; if (bus.mems_SPI_start !== 1'b1 || bus.addr !== 16'd0) begin fails++; $display("FAIL init_rst_start: got %b@%0d required 1@0", bus.mems_SPI_start, bus.addr); end
    prev = cyc;
    for (int i = 0; i < 3; i++) begin
      next_start(16, a, c, ok);
      tests++; if (!ok || a !== exp_a[i] || (c - prev) != 2) begin
        fails++; $display("FAIL init_seq_%0d: got addr %0d gap %0d ok %0d required addr %0d gap 2", i, a, c - prev, ok, exp_a[i]);
      end
      prev = c;
    end
    tests++; if (scan_active !== 1'b1 || line_idx !== 5'd0) begin fails++; $display("FAIL scan_entry: got %b/%0d required 1/0", scan_active, line_idx); end
  endtask

  task automatic test_line_marker();
    logic [15:0] a;
    int          c, gaps;
    bit          ok;
    run_to(16'd487, 600, 1'b0, ok, gaps);
    tests++; if (!ok || gaps != 0) begin fails++; $display("FAIL line_run: got reached %0d bad gaps %0d required 1 and 0", ok, gaps); end
    tests++; if (bus.new_line !== 1'b0 || line_idx !== 5'd0) begin fails++; $display("FAIL line_pre: got %b/%0d required 0/0", bus.new_line, line_idx); end
    next_start(16, a, c, ok);
    tests++; if (!ok || a !== 16'd488 || bus.new_line !== 1'b1 || line_idx !== 5'd1) begin
      fails++; $display("FAIL line_set: got addr %0d new_line %b line %0d required 488/1/1", a, bus.new_line, line_idx);
    end
    repeat (6) @(negedge clk);
    tests++; if (bus.new_line !== 1'b1) begin fails++; $display("FAIL line_hold: got %b required 1", bus.new_line); end
    bus.new_line_FIFO_done = 1'b1;
    @(negedge clk);
    bus.new_line_FIFO_done = 1'b0;
    tests++; if (bus.new_line !== 1'b0) begin fails++; $display("FAIL line_ack: got %b required 0", bus.new_line); end
  endtask

  task automatic test_frame_wrap();
    logic [15:0] a;
    int          c, gaps;
    bit          ok;
    run_to(16'd8647, 9000, 1'b1, ok, gaps);
    tests++; if (!ok || gaps != 0) begin fails++; $display("FAIL frame_run: got reached %0d bad gaps %0d required 1 and 0", ok, gaps); end
    tests++; if (line_idx !== 5'd17 || bus.new_frame !== 1'b0) begin fails++; $display("FAIL frame_pre: got line %0d new_frame %b required 17/0", line_idx, bus.new_frame); end
    next_start(16, a, c, ok);
    tests++; if (!ok || a !== 16'd8 || bus.new_frame !== 1'b1 || bus.new_line !== 1'b0 || line_idx !== 5'd0) begin
      fails++; $display("FAIL frame_wrap: got addr %0d frame %b line_mk %b line %0d required 8/1/0/0", a, bus.new_frame, bus.new_line, line_idx);
    end
    bus.new_frame_FIFO_done = 1'b1;
    @(negedge clk);
    bus.new_frame_FIFO_done = 1'b0;
    tests++; if (bus.new_frame !== 1'b0) begin fails++; $display("FAIL frame_ack: got %b required 0", bus.new_frame); end
  endtask

  task automatic test_marker_race();
    logic [15:0] a;
    int          c, gaps;
    bit          ok;
    run_to(16'd487, 600, 1'b0, ok, gaps);
    tests++; if (!ok || bus.new_line !== 1'b0) begin fails++; $display("FAIL race_pre: got reached %0d new_line %b required 1/0", ok, bus.new_line); end
    @(negedge clk);
    bus.new_line_FIFO_done = 1'b1;
    next_start(4, a, c, ok);
    bus.new_line_FIFO_done = 1'b0;
    tests++; if (!ok || a !== 16'd488 || bus.new_line !== 1'b1) begin fails++; $display("FAIL race_set_wins: got addr %0d new_line %b required 488/1", a, bus.new_line); end
`ifdef MEMS_SCAN_OVERRUN_EN
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b required 0", overrun); end
    run_to(16'd968, 600, 1'b0, ok, gaps);
    tests++; if (!ok || overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got reached %0d overrun %b required 1/1", ok, overrun); end
`endif
  endtask

  task automatic test_pause();
    logic [15:0] a, a2;
    int          c, starts;
    bit          ok;
    next_start(16, a, c, ok);
    bus.mems_SPI_busy = 1'b1;
    pause = 1'b1;
    starts = 0;
    repeat (4) begin @(negedge clk); if (bus.mems_SPI_start === 1'b1) starts++; end
    bus.mems_SPI_busy = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.mems_SPI_start === 1'b1) starts++; end
    tests++; if (!ok || starts != 0) begin fails++; $display("FAIL pause_no_start: got %0d starts required 0", starts); end
    tests++; if (bus.addr !== a) begin fails++; $display("FAIL pause_addr: got %0d required %0d", bus.addr, a); end
    pause = 1'b0;
    next_start(8, a2, c, ok);
    tests++; if (!ok || a2 !== a + 16'd1) begin fails++; $display("FAIL pause_resume: got %0d required %0d", a2, a + 16'd1); end
  endtask

  task automatic test_single_frame();
    int gaps, starts;
    bit ok;
    single_frame = 1'b1;
    run_to(16'd8647, 9000, 1'b1, ok, gaps);
    tests++; if (!ok || gaps != 0) begin fails++; $display("FAIL single_run: got reached %0d bad gaps %0d required 1 and 0", ok, gaps); end
    starts = 0;
    repeat (10) begin @(negedge clk); if (bus.mems_SPI_start === 1'b1) starts++; end
    tests++; if (starts != 0) begin fails++; $display("FAIL single_no_start: got %0d starts required 0", starts); end
    tests++; if (scan_active !== 1'b0 || bus.addr !== 16'd0 || bus.new_frame !== 1'b1) begin
      fails++; $display("FAIL single_idle: got scan %b addr %0d frame %b required 0/0/1", scan_active, bus.addr, bus.new_frame);
    end
    single_frame = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] a;
    int          c, gaps;
    bit          ok;
    mems_soft_reset = 1'b1;
    @(negedge clk);
    mems_soft_reset = 1'b0;
    run_to(16'd10, 16, 1'b0, ok, gaps);
    tests++; if (!ok) begin fails++; $display("FAIL abort_prep: got reached %0d required 1", ok); end
    bus.mems_SPI_busy = 1'b1;
    mems_soft_reset = 1'b1;
    @(negedge clk);
    mems_soft_reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.mems_SPI_start !== 1'b0) begin fails++; $display("FAIL abort_wait_busy: got %b required 0", bus.mems_SPI_start); end
    bus.mems_SPI_busy = 1'b0;
    next_start(8, a, c, ok);
    tests++; if (!ok || a !== 16'd0 || scan_active !== 1'b0 || bus.new_frame !== 1'b0) begin
      fails++; $display("FAIL abort_restart: got addr %0d scan %b frame %b required 0/0/0", a, scan_active, bus.new_frame);
    end
`ifdef MEMS_SCAN_OVERRUN_EN
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b required 0", overrun); end
`endif
    run_to(16'd9, 8, 1'b0, ok, gaps);
    tests++; if (!ok || gaps != 0) begin fails++; $display("FAIL abort_reinit: got reached %0d bad gaps %0d required 1 and 0", ok, gaps); end
  endtask

  task automatic test_rst_mid_busy();
    int starts;
    bus.mems_SPI_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.mems_SPI_start !== 1'b0 || bus.addr !== 16'd0 || scan_active !== 1'b0 || line_idx !== 5'd0 ||
                 bus.new_line !== 1'b0 || bus.new_frame !== 1'b0) begin
      fails++; $display("FAIL rst_async: got start %b addr %0d scan %b line %0d mk %b%b required 0/0/0/0/00",
                        bus.mems_SPI_start, bus.addr, scan_active, line_idx, bus.new_line, bus.new_frame);
    end
    @(negedge clk);
    bus.mems_SPI_busy = 1'b0;
    rst_n = 1'b1;
    starts = 0;
    repeat (6) begin @(negedge clk); if (bus.mems_SPI_start === 1'b1) starts++; end
    tests++; if (starts != 0 || scan_active !== 1'b0) begin fails++; $display("FAIL rst_stays_idle: got %0d starts scan %b required 0/0", starts, scan_active); end
  endtask

  initial begin
    bus.mems_SPI_busy       = 1'b0;
    bus.new_line_FIFO_done  = 1'b0;
    bus.new_frame_FIFO_done = 1'b0;
    test_reset();
    test_init_sequence();
    test_line_marker();
    test_frame_wrap();
    test_marker_race();
    test_pause();
    test_single_frame();
    test_abort();
    test_rst_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
